commutation_ctrl: RTL and testbench
===================================

// Module: commutation_ctrl
// PURPOSE
//  Six-step BLDC commutation sequencer for the e-bike motor drive: converts hall inputs, duty and
//  mode requests into high/low gate requests for phases U, V, W. Outputs feed the per-phase dead-time
//  insertion cells, so this block does not insert dead time. Owns the PWM carrier, the hall debounce
//  and the run/brake/fault mode machine.
// PARAMETERS
//  PWM_W      11  carrier counter width; PWM period = 2**PWM_W clk cycles
//  HALL_FILT   4  consecutive identical synced hall samples required to accept a new code (>=1)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       reset, asynchronous, active-low
//  hall       in   3       raw hall sensors {A,B,C}, asynchronous to clk
//  duty       in   PWM_W   requested duty; on-time = duty clocks per period
//  drv_en     in   1       1 = enable drive
//  brake_n    in   1       0 = regenerative brake request (all low sides on)
//  dir        in   1       0 = forward, 1 = reverse
//  highU/lowU, highV/lowV, highW/lowW  out  1 each  registered gate requests
//  pwm_sync   out  1       1-cycle pulse on carrier wrap (cnt == 2**PWM_W-1)
//  comm_evt   out  1       1-cycle pulse when the accepted hall code changes in RUN
//  hall_fault out  1       high while in FAULT
// BEHAVIOUR
//  Reset: all six gate outputs 0, pwm_sync/comm_evt/hall_fault 0, state IDLE, cnt 0, duty_q 0,
//   hall_q 3'b000 (treated as not yet valid: no FAULT until first filtered code is accepted).
//  Hall path: 2-flop synchronizer; filtered code hall_q updates when the synced value has been stable
//   HALL_FILT consecutive cycles. Codes 000/111 are illegal.
//  Carrier: cnt increments every clk, wraps 2**PWM_W-1 -> 0. duty_q <= duty only on the wrap cycle
//   (glitch-free update). pwm_on = (cnt < duty_q): duty 0 -> never on; max duty -> off 1 clk/period.
//  Table, forward (HI phase, LO phase; third phase floats): 101:U,V 100:U,W 110:V,W 010:V,U
//   011:W,U 001:W,V. Reverse: swap HI and LO roles. dir latched on IDLE->RUN; ignored in RUN.
//  Per phase in RUN: HI -> high=pwm_on, low=~pwm_on; LO -> high=0, low=1; float -> both 0.
//  States (priority FAULT > BRAKE > RUN/IDLE, evaluated every cycle):
//   IDLE : all 0. -> RUN when drv_en & brake_n & legal hall_q.
//   RUN  : table drive. -> IDLE when ~drv_en; -> BRAKE when ~brake_n.
//   BRAKE: highs 0, lows 1. -> IDLE when brake_n (re-enter RUN via IDLE only).
//   FAULT: entered from any state when hall_q is illegal after first accept; all 0, hall_fault=1.
//          -> IDLE only when ~drv_en and hall_q legal.
//  Latency: input/state change to gate outputs = 1 clk (registered); hall edge to output adds
//   2 sync + HALL_FILT cycles.
//  Invariant: never high* & low* both 1 on the same phase in any cycle.
//  Simultaneous: brake and fault same cycle -> FAULT. Hall change on wrap cycle -> new table and new
//   duty both apply from next cycle. comm_evt not issued on the IDLE->RUN entry cycle.
//  Reset mid-operation: all outputs 0 asynchronously; hall filter restarts.
// STRUCTURE
//  Package ebike_pkg: typedef enum comm_state_t {IDLE,RUN,BRAKE,FAULT}; typedef enum phase_t
//   {PH_U,PH_V,PH_W}; localparams HALL_ILL0=3'b000, HALL_ILL1=3'b111.
//  Sub-module hall_filter (#(HALL_FILT)): synchronizer + debounce, outputs hall_q, hall_chg, hall_vld.
//  Remainder (carrier, table, FSM, output regs) stays in commutation_ctrl.
// TESTING
//  1 PWM_W=4, duty=4, hall=101 stable, drv_en=1 -> highU high 4 of every 16 clks, lowU complementary,
//    lowV=1, W both 0; pwm_sync every 16 clks.
//  2 duty 4->12 mid-period -> on-time stays 4 until wrap, then 12; duty=0 -> highU never 1.
//  3 Step hall 101->100->110->010->011->001 fwd, then dir=1 via IDLE -> table and swapped roles
//    match; comm_evt one pulse per accepted change.
//  4 Hall glitch shorter than HALL_FILT cycles -> hall_q unchanged, no comm_evt, outputs unchanged.
//  5 hall=111 held in RUN -> FAULT, all outputs 0, hall_fault=1; drv_en=0 + hall=011 -> IDLE.
//  6 brake_n=0 in RUN -> next clk highs 0/lows 1; rst_n low mid-RUN -> all 0 immediately; every
//    scenario asserts no high*/low* overlap.

Source files
------------

// File: rtl/ebike_pkg.sv
// Shared types and helpers for the e-bike motor drive: controller states,
// phase identifiers and the six-step hall commutation table.
package ebike_pkg;

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} comm_state_t;
    typedef enum logic [1:0] {PH_U, PH_V, PH_W} phase_t;

    localparam logic [2:0] HALL_ILL0 = 3'b000;
    localparam logic [2:0] HALL_ILL1 = 3'b111;

    typedef struct packed {
        phase_t hi;
        phase_t lo;
    } comm_pair_t;

    function automatic logic hall_legal(input logic [2:0] code);
        return (code != HALL_ILL0) && (code != HALL_ILL1);
    endfunction

    // Forward-rotation table; the caller swaps roles for reverse.
    function automatic comm_pair_t comm_lookup(input logic [2:0] code);
        comm_pair_t p;
        p.hi = PH_U;
        p.lo = PH_U;
        case (code)
            3'b101:  begin p.hi = PH_U; p.lo = PH_V; end
            3'b100:  begin p.hi = PH_U; p.lo = PH_W; end
            3'b110:  begin p.hi = PH_V; p.lo = PH_W; end
            3'b010:  begin p.hi = PH_V; p.lo = PH_U; end
            3'b011:  begin p.hi = PH_W; p.lo = PH_U; end
            3'b001:  begin p.hi = PH_W; p.lo = PH_V; end
            default: begin p.hi = PH_U; p.lo = PH_U; end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Hall sensor front end: two-flop synchronizer followed by a debounce that only
// accepts a new code after HALL_FILT consecutive identical synced samples.
module hall_filter
    import ebike_pkg::*;
#(
    parameter int HALL_FILT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hall,
    output logic [2:0] hall_q,
    output logic       hall_chg,
    output logic       hall_vld
);

    localparam int CW = $clog2(HALL_FILT + 1);

    logic [2:0]    sync1_q, sync2_q, prev_q, code_q;
    logic [2:0]    code_d;
    logic [CW-1:0] stab_q, stab_d;
    logic          chg_q, chg_d, vld_q, vld_d, accept;

    // stab counts how many consecutive cycles the synced code has held, itself included
    always_comb begin
        stab_d = CW'(1);
        if (sync2_q == prev_q) begin
            stab_d = (stab_q == CW'(HALL_FILT)) ? stab_q : stab_q + CW'(1);
        end
        accept = (stab_d == CW'(HALL_FILT)) && (sync2_q != code_q);
        code_d = accept ? sync2_q : code_q;
        chg_d  = accept;
        vld_d  = vld_q | accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
            stab_q  <= '0;
            code_q  <= 3'b000;
            chg_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            sync1_q <= hall;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
            code_q  <= code_d;
            chg_q   <= chg_d;
            vld_q   <= vld_d;
        end
    end

    assign hall_q   = code_q;
    assign hall_chg = chg_q;
    assign hall_vld = vld_q;

endmodule

// File: rtl/commutation_ctrl.sv
// Six-step BLDC commutation sequencer: PWM carrier, run/brake/fault mode machine
// and registered gate requests for phases U, V, W (dead time is added downstream).
module commutation_ctrl
    import ebike_pkg::*;
#(
    parameter int PWM_W     = 11,
    parameter int HALL_FILT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       hall,
    input  logic [PWM_W-1:0] duty,
    input  logic             drv_en,
    input  logic             brake_n,
    input  logic             dir,
    output logic             highU,
    output logic             lowU,
    output logic             highV,
    output logic             lowV,
    output logic             highW,
    output logic             lowW,
    output logic             pwm_sync,
    output logic             comm_evt,
    output logic             hall_fault
);

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [2:0]       hall_q;
    logic             hall_chg, hall_vld;
    logic [PWM_W-1:0] cnt_q, cnt_d, duty_q, duty_d;
    comm_state_t      state_q, state_d;
    logic             dir_q, dir_d;
    logic [2:0]       high_q, high_d, low_q, low_d;
    logic             pwm_sync_q, pwm_sync_d, comm_evt_q, comm_evt_d, fault_q, fault_d;
    logic             pwm_on, fault_cond;
    comm_pair_t       pair;
    logic [2:0]       hi_raw, lo_raw, hi_sel, lo_sel;

    hall_filter #(.HALL_FILT(HALL_FILT)) u_hall (
        .clk      (clk),
        .rst_n    (rst_n),
        .hall     (hall),
        .hall_q   (hall_q),
        .hall_chg (hall_chg),
        .hall_vld (hall_vld)
    );

    // duty is only sampled on the wrap cycle so a period never sees a torn compare value
    always_comb begin
        cnt_d      = cnt_q + PWM_W'(1);
        duty_d     = (cnt_q == CNT_MAX) ? duty : duty_q;
        pwm_on     = (cnt_q < duty_q);
        pwm_sync_d = (cnt_d == CNT_MAX);
    end

    always_comb begin
        fault_cond = hall_vld && !hall_legal(hall_q);
        state_d    = state_q;
        if (fault_cond) begin
            state_d = FAULT;
        end else if (state_q == FAULT) begin
            if (!drv_en) state_d = IDLE;
        end else if (!brake_n) begin
            state_d = BRAKE;
        end else begin
            case (state_q)
                IDLE:    if (drv_en && hall_vld && hall_legal(hall_q)) state_d = RUN;
                RUN:     if (!drv_en) state_d = IDLE;
                BRAKE:   state_d = IDLE;
                default: state_d = state_q;
            endcase
        end

        dir_d = (state_q != RUN && state_d == RUN) ? dir : dir_q;

        // Gate requests follow the next state so every change lands one clock later
        pair   = comm_lookup(hall_q);
        hi_raw = 3'b001 << pair.hi;
        lo_raw = 3'b001 << pair.lo;
        hi_sel = dir_d ? lo_raw : hi_raw;
        lo_sel = dir_d ? hi_raw : lo_raw;
        high_d = 3'b000;
        low_d  = 3'b000;
        if (state_d == RUN && hall_legal(hall_q)) begin
            high_d = hi_sel & {3{pwm_on}};
            low_d  = (hi_sel & {3{~pwm_on}}) | lo_sel;
        end else if (state_d == BRAKE) begin
            low_d  = 3'b111;
        end

        comm_evt_d = hall_chg && (state_q == RUN) && (state_d == RUN);
        fault_d    = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            duty_q     <= '0;
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            high_q     <= 3'b000;
            low_q      <= 3'b000;
            pwm_sync_q <= 1'b0;
            comm_evt_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            state_q    <= state_d;
            dir_q      <= dir_d;
            high_q     <= high_d;
            low_q      <= low_d;
            pwm_sync_q <= pwm_sync_d;
            comm_evt_q <= comm_evt_d;
            fault_q    <= fault_d;
        end
    end

    assign highU      = high_q[0];
    assign lowU       = low_q[0];
    assign highV      = high_q[1];
    assign lowV       = low_q[1];
    assign highW      = high_q[2];
    assign lowW       = low_q[2];
    assign pwm_sync   = pwm_sync_q;
    assign comm_evt   = comm_evt_q;
    assign hall_fault = fault_q;

endmodule

// File: tb/tb_commutation_ctrl.sv
// Directed bench for commutation_ctrl with PWM_W=4 (16-clock period) and HALL_FILT=4.
module tb_commutation_ctrl;

    localparam int PWM_W     = 4;
    localparam int HALL_FILT = 4;
    localparam int U = 0, V = 1, W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [2:0]       hall;
    logic [PWM_W-1:0] duty;
    logic             drv_en, brake_n, dir;
    logic             highU, lowU, highV, lowV, highW, lowW;
    logic             pwm_sync, comm_evt, hall_fault;

    int checks = 0;
    int errors = 0;
    int evt_cnt = 0;

    commutation_ctrl #(.PWM_W(PWM_W), .HALL_FILT(HALL_FILT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hall       (hall),
        .duty       (duty),
        .drv_en     (drv_en),
        .brake_n    (brake_n),
        .dir        (dir),
        .highU      (highU),
        .lowU       (lowU),
        .highV      (highV),
        .lowV       (lowV),
        .highW      (highW),
        .lowW       (lowW),
        .pwm_sync   (pwm_sync),
        .comm_evt   (comm_evt),
        .hall_fault (hall_fault)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (comm_evt === 1'b1) evt_cnt++;
    end

    always @(negedge clk) begin
        checks++;
        assert (({highW, highV, highU} & {lowW, lowV, lowU}) === 3'b000) else begin
            errors++;
            $error("[TB] FAIL overlap: observed high=%b low=%b expected no common bit",
                   {highW, highV, highU}, {lowW, lowV, lowU});
        end
    end

    // Waits for a carrier wrap, then inspects one full period of gate outputs.
    task automatic check_period(input string tag, input int hi, input int lo, input int exp_on);
        bit         found;
        int         on_cnt, sync_cnt, bad;
        logic [2:0] h, l;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pwm_sync === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check_vec({tag, "_sync_found"}, 32'(found), 32'd1);
        on_cnt   = 0;
        sync_cnt = 0;
        bad      = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            h = {highW, highV, highU};
            l = {lowW, lowV, lowU};
            if (pwm_sync === 1'b1) sync_cnt++;
            for (int p = 0; p < 3; p++) begin
                if (p == hi) begin
                    if (h[p] === 1'b1) on_cnt++;
                    if (l[p] !== ~h[p]) bad++;
                end else if (p == lo) begin
                    if (h[p] !== 1'b0 || l[p] !== 1'b1) bad++;
                end else begin
                    if (h[p] !== 1'b0 || l[p] !== 1'b0) bad++;
                end
            end
        end
        check_vec({tag, "_on_time"}, on_cnt, exp_on);
        check_vec({tag, "_pattern"}, bad, 0);
        check_vec({tag, "_sync_per_period"}, sync_cnt, 1);
    endtask

    task automatic step_hall(input string tag, input logic [2:0] code, input int hi, input int lo);
        int e0;
        e0   = evt_cnt;
        hall = code;
        repeat (10) @(negedge clk);
        check_period(tag, hi, lo, 4);
        check_vec({tag, "_evt"}, evt_cnt - e0, 1);
    endtask

    initial begin
        int e0, partial;
        hall    = 3'b101;
        duty    = 4'd4;
        drv_en  = 1'b0;
        brake_n = 1'b1;
        dir     = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("reset_gates", {highW, highV, highU, lowW, lowV, lowU}, 0);
        check_vec("reset_pwm_sync", pwm_sync, 0);
        check_vec("reset_comm_evt", comm_evt, 0);
        check_vec("reset_hall_fault", hall_fault, 0);

        rst_n  = 1'b1;
        drv_en = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("no_fault_before_accept", hall_fault, 0);
        repeat (18) @(negedge clk);
        check_vec("entry_no_evt", evt_cnt, 0);

        $display("[TB] scenario 1: duty 4, hall 101 forward");
        check_period("t1", U, V, 4);

        $display("[TB] scenario 2: duty updates only on wrap");
        repeat (2) @(negedge clk);
        duty    = 4'd12;
        partial = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (highU === 1'b1) partial++;
        end
        check_vec("t2_old_duty_until_wrap", partial, 3);
        check_vec("t2_wrap_at_end", pwm_sync, 1);
        check_period("t2_duty12", U, V, 12);
        duty = 4'd15;
        check_period("t2_duty15", U, V, 15);
        duty = 4'd0;
        check_period("t2_duty0", U, V, 0);
        duty = 4'd4;
        check_period("t2_duty4", U, V, 4);

        $display("[TB] scenario 3: forward table, then reverse via IDLE");
        step_hall("t3_100", 3'b100, U, W);
        step_hall("t3_110", 3'b110, V, W);
        step_hall("t3_010", 3'b010, V, U);
        step_hall("t3_011", 3'b011, W, U);
        step_hall("t3_001", 3'b001, W, V);
        drv_en = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("t3_idle_gates", {highW, highV, highU, lowW, lowV, lowU}, 0);
        e0     = evt_cnt;
        dir    = 1'b1;
        drv_en = 1'b1;
        repeat (3) @(negedge clk);
        check_period("t3_rev_001", V, W, 4);
        check_vec("t3_reentry_no_evt", evt_cnt - e0, 0);
        dir = 1'b0;
        check_period("t3_dir_ignored_in_run", V, W, 4);
        step_hall("t3_rev_101", 3'b101, V, U);

        $display("[TB] scenario 4: hall glitches around the filter length");
        e0   = evt_cnt;
        hall = 3'b100;
        repeat (HALL_FILT - 1) @(negedge clk);
        hall = 3'b101;
        repeat (10) @(negedge clk);
        check_vec("t4_short_glitch_evt", evt_cnt - e0, 0);
        check_period("t4_short_glitch", V, U, 4);
        e0   = evt_cnt;
        hall = 3'b100;
        repeat (HALL_FILT) @(negedge clk);
        hall = 3'b101;
        repeat (12) @(negedge clk);
        check_vec("t4_filter_length_pulse_evt", evt_cnt - e0, 2);
        check_period("t4_after_pulse", V, U, 4);

        $display("[TB] scenario 5: illegal hall -> FAULT");
        hall = 3'b111;
        repeat (10) @(negedge clk);
        check_vec("t5_fault_flag", hall_fault, 1);
        check_vec("t5_fault_gates", {highW, highV, highU, lowW, lowV, lowU}, 0);
        hall = 3'b011;
        repeat (10) @(negedge clk);
        check_vec("t5_fault_held_while_enabled", hall_fault, 1);
        drv_en = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("t5_fault_cleared", hall_fault, 0);
        check_vec("t5_idle_gates", {highW, highV, highU, lowW, lowV, lowU}, 0);
        drv_en = 1'b1;
        repeat (3) @(negedge clk);
        check_period("t5_run_011", W, U, 4);

        $display("[TB] scenario 6: brake, brake with fault, async reset");
        brake_n = 1'b0;
        @(negedge clk);
        check_vec("t6_brake_highs", {highW, highV, highU}, 3'b000);
        check_vec("t6_brake_lows", {lowW, lowV, lowU}, 3'b111);
        brake_n = 1'b1;
        repeat (3) @(negedge clk);
        check_period("t6_after_brake", W, U, 4);
        brake_n = 1'b0;
        hall    = 3'b111;
        repeat (10) @(negedge clk);
        check_vec("t6_brake_fault_flag", hall_fault, 1);
        check_vec("t6_brake_fault_gates", {highW, highV, highU, lowW, lowV, lowU}, 0);
        hall    = 3'b101;
        brake_n = 1'b1;
        drv_en  = 1'b0;
        repeat (10) @(negedge clk);
        check_vec("t6_fault_to_idle", hall_fault, 0);
        drv_en = 1'b1;
        repeat (3) @(negedge clk);
        check_period("t6_run_101", U, V, 4);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_vec("t6_async_reset_gates", {highW, highV, highU, lowW, lowV, lowU}, 0);
        check_vec("t6_async_reset_flags", {pwm_sync, comm_evt, hall_fault}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("t6_filter_restart_gates", {highW, highV, highU, lowW, lowV, lowU}, 0);
        repeat (10) @(negedge clk);
        check_period("t6_after_reset", U, V, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
